sha256_compress_core: RTL
=========================

// Module: sha256_compress_core
// PURPOSE
//  Generic SHA-256 compression engine: one full 512-bit block (16 words) plus an 8-word chaining value in, 8-word digest out.
//  Configurable rounds unrolled per clock; valid/ready handshake on input and output; 16-entry sliding message schedule.
//  Sits under the bitcoin-hash top as the per-nonce worker; replaces the fixed-phase single-round worker for phases 1-3.
// PARAMETERS
//  ROUNDS_PER_CYCLE  1   SHA rounds executed per clock in ROUND state; legal 1,2,4,8 (must divide 64)
//  NONCE_IDX         3   message word index replaced by nonce when SHA256_NONCE_INSERT_EN defined; legal 0..15
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       asynchronous active-low reset
//  in_valid   in   1       block + chaining value present
//  in_ready   out  1       core can accept a block (= state IDLE)
//  hi         in   32x8    chaining value H0..H7 (IV for first block)
//  msg        in   32x16   message words W0..W15, big-endian word order, padding already applied
//  nonce      in   32      nonce word (used only with SHA256_NONCE_INSERT_EN)
//  out_valid  out  1       digest valid, held until accepted
//  out_ready  in   1       downstream accepts digest
//  ho         out  32x8    digest = hi + final a..h (mod 2^32 per word)
//  busy       out  1       high in ROUND and FINAL
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, ho all 0, round counter 0. Reset mid-block aborts; no partial digest emitted.
//  - States: IDLE -> ROUND -> FINAL -> DONE -> IDLE.
//  - IDLE: on in_valid&in_ready edge capture hi into H regs and a..h, msg into W[0..15], round=0; go ROUND.
//  - ROUND: each clock run ROUNDS_PER_CYCLE chained rounds t..t+R-1 using K[t] and W window head; window shifts by R, new words
//    W[t+16] = W[t] + s0(W[t+1]) + W[t+9] + s1(W[t+14]) computed combinationally inside the unrolled chain. round += R;
//    when round+R == 64 go FINAL.
//  - FINAL: ho[i] <= H[i] + {a..h}[i]; out_valid <= 1; go DONE.
//  - DONE: hold ho and out_valid; on out_valid&out_ready edge clear out_valid, go IDLE. ho retains last digest until next FINAL.
//  - Latency: out_valid rises 64/R + 1 clocks after the accepting edge (R=1: 65, R=4: 17). Throughput one block per 64/R+3 clocks min.
//  - in_valid outside IDLE ignored, nothing captured; inputs need only be stable on the accepting edge.
//  - out_ready asserted before out_valid has no effect; out_ready held high completes handshake on first DONE cycle.
//  - All arithmetic 32-bit mod 2^32; rotations constant; round counter 7 bits, never wraps (reset to 0 on accept).
// CONFIGURATION
//  SHA256_NONCE_INSERT_EN defined: captured W[NONCE_IDX] = nonce; msg[NONCE_IDX] ignored. Lets the top share one msg bus across workers.
//  Not defined: nonce port unused; W[NONCE_IDX] = msg[NONCE_IDX].
// TESTING
//  T1 R=1, hi=IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, msg=61626380,0x0 x14,00000018 ("abc")
//     -> out_valid 65 clocks after accept, ho=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
//  T2 R=4, same "abc" block -> identical ho, out_valid 17 clocks after accept; busy high for exactly 17 clocks.
//  T3 backpressure: out_ready low 10 clocks after out_valid, in_valid pulsed meanwhile -> ho/out_valid stable, in_ready 0, no capture;
//     out_ready=1 -> out_valid 0 and in_ready 1 next clock.
//  T4 reset_n low at round 30 -> same cycle out_valid 0, ho 0, in_ready 1; then msg=80000000,0x0 x15, IV ->
//     ho=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
//  T5 SHA256_NONCE_INSERT_EN, NONCE_IDX=3: "abc" block with msg[3]=deadbeef, nonce=00000000 -> "abc" digest of T1;
//     without macro the same stimulus -> ho != T1 digest.
//  T6 back-to-back: in_valid held high, out_ready high, 3 blocks (abc, empty, abc) -> 3 correct digests in order, no block dropped.

Source files
------------

// File: rtl/sha256_compress_core.sv
// ---------------------------------------------------------------------------
// sha256_compress_core
//   SHA-256 compression of one 512-bit block against an 8-word chaining value.
//   ROUNDS_PER_CYCLE rounds are unrolled per clock. The 16-word message window
//   slides by ROUNDS_PER_CYCLE each clock, and the words it needs next are
//   expanded inside the same unrolled chain.
//
//   Optional build macro: SHA256_NONCE_INSERT_EN
//     defined   : captured W[NONCE_IDX] is taken from the nonce port.
//     undefined : nonce port unused; W[NONCE_IDX] comes from msg.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   block + chaining value present
//   in_ready   core can accept a block (IDLE)
//   hi[8]      chaining value H0..H7 (index 0 = H0)
//   msg[16]    padded message words W0..W15 (index 0 = W0)
//   nonce      nonce word (nonce-insert build only)
//   out_valid  digest valid, held until accepted
//   out_ready  downstream accepts the digest
//   ho[8]      digest words (index 0 = first digest word)
//   busy       high while rounds or the final add are in progress
// ---------------------------------------------------------------------------
module sha256_compress_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int NONCE_IDX        = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0][31:0]  hi,
    input  logic [15:0][31:0] msg,
    input  logic [31:0]       nonce,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0][31:0]  ho,
    output logic              busy
);

    localparam int R = ROUNDS_PER_CYCLE;

`ifdef SHA256_NONCE_INSERT_EN
    localparam bit NONCE_EN = 1'b1;
`else
    localparam bit NONCE_EN = 1'b0;
`endif

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Working state is packed a..h at indices 0..7.
    function automatic logic [7:0][31:0] sha_round(input logic [7:0][31:0] s,
                                                   input logic [31:0] k,
                                                   input logic [31:0] w);
        logic [31:0]      t1;
        logic [31:0]      t2;
        logic [7:0][31:0] r;
        t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25))
                  + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
        t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22))
           + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        r[0] = t1 + t2;
        r[1] = s[0];
        r[2] = s[1];
        r[3] = s[2];
        r[4] = s[3] + t1;
        r[5] = s[4];
        r[6] = s[5];
        r[7] = s[6];
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [6:0]        round_q;
    logic [7:0][31:0]  h_q;
    logic [7:0][31:0]  st_q;
    logic [15:0][31:0] w_q;

    logic [15:0][31:0] capt_w;
    logic [31:0]       w_ext [16 + R];
    logic [7:0][31:0]  st_round;
    logic              accept;
    logic              last_step;

    assign accept    = in_valid && (state_q == IDLE);
    assign last_step = (7'(round_q + 7'(R)) == 7'd64);

    // Block capture, with optional nonce substitution.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            capt_w[i] = (NONCE_EN && i == NONCE_IDX) ? nonce : msg[i];
        end
    end

    // Unrolled rounds: round j consumes w_ext[j]; words 16.. are expanded
    // just ahead of the chain so the window can slide by R.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = w_q[i];
        end
        for (int j = 0; j < R; j++) begin
            w_ext[16 + j] = w_ext[j] + ssig0(w_ext[j + 1]) + w_ext[j + 9] + ssig1(w_ext[j + 14]);
        end
        st_round = st_q;
        for (int j = 0; j < R; j++) begin
            st_round = sha_round(st_round, K[6'(round_q[5:0] + 6'(j))], w_ext[j]);
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (last_step) state_d = FINAL;
            end
            FINAL: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            round_q   <= '0;
            out_valid <= 1'b0;
            ho        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) round_q <= '0;
            else if (state_q == ROUND) round_q <= 7'(round_q + 7'(R));
            if (state_q == FINAL) begin
                out_valid <= 1'b1;
                for (int i = 0; i < 8; i++) ho[i] <= h_q[i] + st_q[i];
            end else if (state_q == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: the datapath registers carry no reset; every block fully reloads
    // them on accept before any value is consumed, and an aborted block is
    // discarded by the control FSM.
    always_ff @(posedge clk) begin
        if (accept) begin
            h_q  <= hi;
            st_q <= hi;
            w_q  <= capt_w;
        end else if (state_q == ROUND) begin
            st_q <= st_round;
            for (int i = 0; i < 16; i++) w_q[i] <= w_ext[R + i];
        end
    end

endmodule
